vc_input_buffer: RTL and testbench

VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

---
 rtl/noc_pkg.sv | 16 +
 rtl/vc_fifo.sv | 52 +++++
 rtl/vc_input_buffer.sv | 101 ++++++++++
 tb/tb_vc_input_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types and constants.
//   flit_t    : default flit word (16 bits)
//   vc_idx_t  : wide VC index used for range-safe VC compares
//   ERR_OVF / ERR_UDF : bit positions inside the 2-bit error vector
package noc_pkg;

    localparam int FLIT_W   = 16;
    typedef logic [FLIT_W-1:0] flit_t;

    localparam int VC_IDX_W = 8;
    typedef logic [VC_IDX_W-1:0] vc_idx_t;

    localparam int ERR_OVF  = 0;
    localparam int ERR_UDF  = 1;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular FIFO: storage, pointers and occupancy.
// The enables arrive already qualified by the parent (never write when
// full without a same-cycle read, never read when empty).
//   clk, reset  : clock, async active-low reset
//   wr_en/wr_data : accepted write
//   rd_en       : accepted read (advances read pointer)
//   rd_data     : flit at the read pointer (combinational)
//   count       : current occupancy, 0..DEPTH
module vc_fifo
    import noc_pkg::*;
#(
    parameter  int DATA_W = $bits(flit_t),
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    assign rd_data = mem[rptr];

    // DEPTH is a power of two, so the natural pointer rollover wraps
    // DEPTH-1 back to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            if (wr_en && !rd_en)      count <= count + 1'b1;
            else if (rd_en && !wr_en) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Multi-VC input buffer: one vc_fifo per virtual channel, write/read
// decode, registered read data path and error pulses.
// Optional feature macro: VC_INPUT_BUFFER_CREDIT_EN adds credit_o.
//   clk, reset     : clock, async active-low reset
//   buf_write_i, buf_wvc_i, buf_data_i : write request, target VC, flit
//   buf_read_i, buf_rvc_i              : read request, source VC
//   buf_data_o, buf_valid_o            : registered read flit / valid
//   buf_empty_o, buf_full_o            : per-VC flags from counts
//   buf_count_o    : per-VC occupancy, VC0 in LSBs
//   buf_err_o      : bit0 overflow pulse, bit1 underflow pulse
//   credit_o       : (CREDIT_EN only) per-VC one-cycle credit per read
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter  int DATA_W = $bits(flit_t),
    parameter  int DEPTH  = 8,
    parameter  int NUM_VC = 2,
    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    buf_write_i,
    input  logic [VC_W-1:0]         buf_wvc_i,
    input  logic [DATA_W-1:0]       buf_data_i,
    input  logic                    buf_read_i,
    input  logic [VC_W-1:0]         buf_rvc_i,
    output logic [DATA_W-1:0]       buf_data_o,
    output logic                    buf_valid_o,
    output logic [NUM_VC-1:0]       buf_empty_o,
    output logic [NUM_VC-1:0]       buf_full_o,
    output logic [NUM_VC*CNT_W-1:0] buf_count_o,
`ifdef VC_INPUT_BUFFER_CREDIT_EN
    output logic [NUM_VC-1:0]       credit_o,
`endif
    output logic [1:0]              buf_err_o
);

    logic [NUM_VC-1:0]             wr_sel, rd_sel, wr_en, rd_en;
    logic [NUM_VC-1:0]             empty, full;
    logic [NUM_VC-1:0][CNT_W-1:0]  cnt;
    logic [NUM_VC-1:0][DATA_W-1:0] rd_flit;
    logic [DATA_W-1:0]             rd_mux;

    // Per-VC decode. Out-of-range VC indices match no lane, so they fall
    // through to the error pulses below with no state change.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign wr_sel[v] = buf_write_i && (vc_idx_t'(buf_wvc_i) == vc_idx_t'(v));
        assign rd_sel[v] = buf_read_i  && (vc_idx_t'(buf_rvc_i) == vc_idx_t'(v));
        assign empty[v]  = (cnt[v] == '0);
        assign full[v]   = (cnt[v] == CNT_W'(DEPTH));
        assign rd_en[v]  = rd_sel[v] && !empty[v];
        // A full VC still takes a write if the same VC is read this cycle.
        assign wr_en[v]  = wr_sel[v] && (!full[v] || rd_en[v]);

        vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[v]),
            .wr_data (buf_data_i),
            .rd_en   (rd_en[v]),
            .rd_data (rd_flit[v]),
            .count   (cnt[v])
        );
    end

    // rd_en is one-hot or zero, so an OR-mux suffices.
    always_comb begin
        rd_mux = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_en[v]) rd_mux = rd_mux | rd_flit[v];
        end
    end

    assign buf_empty_o = empty;
    assign buf_full_o  = full;
    assign buf_count_o = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_data_o  <= '0;
            buf_valid_o <= 1'b0;
            buf_err_o   <= '0;
`ifdef VC_INPUT_BUFFER_CREDIT_EN
            credit_o    <= '0;
`endif
        end else begin
            buf_valid_o <= |rd_en;
            if (|rd_en) buf_data_o <= rd_mux;
            buf_err_o[ERR_OVF] <= buf_write_i && !(|wr_en);
            buf_err_o[ERR_UDF] <= buf_read_i  && !(|rd_en);
`ifdef VC_INPUT_BUFFER_CREDIT_EN
            credit_o    <= rd_en;
`endif
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;
    import noc_pkg::*;

    logic        clk;
    logic        reset;
    logic        buf_write_i;
    logic [0:0]  buf_wvc_i;
    logic [15:0] buf_data_i;
    logic        buf_read_i;
    logic [0:0]  buf_rvc_i;
    logic [15:0] buf_data_o;
    logic        buf_valid_o;
    logic [1:0]  buf_empty_o;
    logic [1:0]  buf_full_o;
    logic [7:0]  buf_count_o;
    logic [1:0]  buf_err_o;
`ifdef VC_INPUT_BUFFER_CREDIT_EN
    logic [1:0]  credit_o;
`endif

    int checks = 0;
    int errors = 0;

    vc_input_buffer #(.DATA_W(16), .DEPTH(8), .NUM_VC(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .buf_write_i (buf_write_i),
        .buf_wvc_i   (buf_wvc_i),
        .buf_data_i  (buf_data_i),
        .buf_read_i  (buf_read_i),
        .buf_rvc_i   (buf_rvc_i),
        .buf_data_o  (buf_data_o),
        .buf_valid_o (buf_valid_o),
        .buf_empty_o (buf_empty_o),
        .buf_full_o  (buf_full_o),
        .buf_count_o (buf_count_o),
`ifdef VC_INPUT_BUFFER_CREDIT_EN
        .credit_o    (credit_o),
`endif
        .buf_err_o   (buf_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        buf_write_i = 1'b0;
        buf_read_i  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        buf_wvc_i = '0; buf_rvc_i = '0; buf_data_i = '0;
        #12;
        checks++; if (buf_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", buf_valid_o); end
        checks++; if (buf_data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", buf_data_o); end
        checks++; if (buf_empty_o !== 2'b11) begin errors++; $display("FAIL reset_empty got %b want 11", buf_empty_o); end
        checks++; if (buf_full_o !== 2'b00) begin errors++; $display("FAIL reset_full got %b want 00", buf_full_o); end
        checks++; if (buf_count_o !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", buf_count_o); end
        checks++; if (buf_err_o !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", buf_err_o); end
        step();
        reset = 1'b1;
    endtask

    task automatic test_single();
        buf_write_i = 1'b1; buf_wvc_i = 1'b0; buf_data_i = 16'h8000;
        step();
        idle();
        checks++; if (buf_count_o[3:0] !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", buf_count_o[3:0]); end
        buf_read_i = 1'b1; buf_rvc_i = 1'b0;
        step();
        idle();
        checks++; if (buf_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", buf_valid_o); end
        checks++; if (buf_data_o !== 16'h8000) begin errors++; $display("FAIL single_data got %h want 8000", buf_data_o); end
        checks++; if (buf_empty_o[0] !== 1'b1) begin errors++; $display("FAIL single_empty got %0b want 1", buf_empty_o[0]); end
`ifdef VC_INPUT_BUFFER_CREDIT_EN
        checks++; if (credit_o !== 2'b01) begin errors++; $display("FAIL single_credit got %b want 01", credit_o); end
`endif
        step();
        checks++; if (buf_valid_o !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %0b want 0", buf_valid_o); end
        checks++; if (buf_data_o !== 16'h8000) begin errors++; $display("FAIL single_hold got %h want 8000", buf_data_o); end
`ifdef VC_INPUT_BUFFER_CREDIT_EN
        checks++; if (credit_o !== 2'b00) begin errors++; $display("FAIL single_credit_idle got %b want 00", credit_o); end
`endif
    endtask

    task automatic test_full();
        for (int i = 1; i <= 8; i++) begin
            buf_write_i = 1'b1; buf_wvc_i = 1'b1; buf_data_i = flit_t'(i);
            step();
        end
        checks++; if (buf_full_o[1] !== 1'b1) begin errors++; $display("FAIL full_flag got %0b want 1", buf_full_o[1]); end
        checks++; if (buf_count_o[7:4] !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", buf_count_o[7:4]); end
        buf_data_i = 16'h0009;
        step();
        idle();
        checks++; if (buf_err_o !== 2'b01) begin errors++; $display("FAIL ovf_err got %b want 01", buf_err_o); end
        checks++; if (buf_count_o[7:4] !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", buf_count_o[7:4]); end
        step();
        checks++; if (buf_err_o !== 2'b00) begin errors++; $display("FAIL ovf_pulse got %b want 00", buf_err_o); end
        for (int i = 1; i <= 8; i++) begin
            buf_read_i = 1'b1; buf_rvc_i = 1'b1;
            step();
            checks++; if (buf_valid_o !== 1'b1 || buf_data_o !== flit_t'(i)) begin
                errors++; $display("FAIL full_drain%0d got v=%0b d=%h want v=1 d=%h", i, buf_valid_o, buf_data_o, flit_t'(i)); end
`ifdef VC_INPUT_BUFFER_CREDIT_EN
            checks++; if (credit_o !== 2'b10) begin errors++; $display("FAIL full_credit%0d got %b want 10", i, credit_o); end
`endif
        end
        idle();
        checks++; if (buf_empty_o[1] !== 1'b1) begin errors++; $display("FAIL full_drained got %0b want 1", buf_empty_o[1]); end
    endtask

    task automatic test_full_rw();
        flit_t exp;
        for (int i = 0; i < 8; i++) begin
            buf_write_i = 1'b1; buf_wvc_i = 1'b0; buf_data_i = flit_t'(16'h10 + i);
            step();
        end
        buf_data_i = 16'hAAAA; buf_read_i = 1'b1; buf_rvc_i = 1'b0;
        step();
        idle();
        checks++; if (buf_err_o !== 2'b00) begin errors++; $display("FAIL fullrw_err got %b want 00", buf_err_o); end
        checks++; if (buf_count_o[3:0] !== 4'd8) begin errors++; $display("FAIL fullrw_count got %0d want 8", buf_count_o[3:0]); end
        checks++; if (buf_valid_o !== 1'b1 || buf_data_o !== 16'h0010) begin
            errors++; $display("FAIL fullrw_data got v=%0b d=%h want v=1 d=0010", buf_valid_o, buf_data_o); end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? flit_t'(16'h11 + i) : 16'hAAAA;
            buf_read_i = 1'b1; buf_rvc_i = 1'b0;
            step();
            checks++; if (buf_valid_o !== 1'b1 || buf_data_o !== exp) begin
                errors++; $display("FAIL fullrw_drain%0d got v=%0b d=%h want v=1 d=%h", i, buf_valid_o, buf_data_o, exp); end
        end
        idle();
        checks++; if (buf_empty_o[0] !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %0b want 1", buf_empty_o[0]); end
    endtask

    task automatic test_empty_read();
        buf_read_i = 1'b1; buf_rvc_i = 1'b1;
        buf_write_i = 1'b1; buf_wvc_i = 1'b1; buf_data_i = 16'h1234;
        step();
        idle();
        checks++; if (buf_valid_o !== 1'b0) begin errors++; $display("FAIL udf_valid got %0b want 0", buf_valid_o); end
        checks++; if (buf_err_o !== 2'b10) begin errors++; $display("FAIL udf_err got %b want 10", buf_err_o); end
        checks++; if (buf_count_o[7:4] !== 4'd1) begin errors++; $display("FAIL udf_count got %0d want 1", buf_count_o[7:4]); end
        checks++; if (buf_data_o !== 16'hAAAA) begin errors++; $display("FAIL udf_hold got %h want aaaa", buf_data_o); end
`ifdef VC_INPUT_BUFFER_CREDIT_EN
        checks++; if (credit_o !== 2'b00) begin errors++; $display("FAIL udf_credit got %b want 00", credit_o); end
`endif
        buf_read_i = 1'b1; buf_rvc_i = 1'b1;
        step();
        idle();
        checks++; if (buf_valid_o !== 1'b1 || buf_data_o !== 16'h1234) begin
            errors++; $display("FAIL udf_later got v=%0b d=%h want v=1 d=1234", buf_valid_o, buf_data_o); end
        checks++; if (buf_err_o !== 2'b00) begin errors++; $display("FAIL udf_pulse got %b want 00", buf_err_o); end
    endtask

    task automatic test_diff_vc();
        buf_write_i = 1'b1; buf_wvc_i = 1'b0; buf_data_i = 16'h0055;
        step();
        buf_wvc_i = 1'b1; buf_data_i = 16'h0066; buf_read_i = 1'b1; buf_rvc_i = 1'b0;
        step();
        idle();
        checks++; if (buf_valid_o !== 1'b1 || buf_data_o !== 16'h0055) begin
            errors++; $display("FAIL diff_data got v=%0b d=%h want v=1 d=0055", buf_valid_o, buf_data_o); end
        checks++; if (buf_count_o !== 8'h10) begin errors++; $display("FAIL diff_count got %h want 10", buf_count_o); end
        buf_read_i = 1'b1; buf_rvc_i = 1'b1;
        step();
        idle();
        checks++; if (buf_data_o !== 16'h0066 || buf_count_o !== 8'h00) begin
            errors++; $display("FAIL diff_vc1 got d=%h cnt=%h want d=0066 cnt=00", buf_data_o, buf_count_o); end
    endtask

    task automatic test_wrap();
        flit_t exp;
        for (int i = 0; i < 12; i++) begin
            exp = flit_t'(16'h100 + i);
            buf_write_i = 1'b1; buf_wvc_i = 1'b0; buf_data_i = exp;
            step();
            idle();
            buf_read_i = 1'b1; buf_rvc_i = 1'b0;
            step();
            idle();
            checks++; if (buf_valid_o !== 1'b1 || buf_data_o !== exp || buf_err_o !== 2'b00) begin
                errors++; $display("FAIL wrap%0d got v=%0b d=%h e=%b want v=1 d=%h e=00", i, buf_valid_o, buf_data_o, buf_err_o, exp); end
        end
        checks++; if (buf_count_o[3:0] !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", buf_count_o[3:0]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            buf_write_i = 1'b1; buf_wvc_i = 1'b0; buf_data_i = flit_t'(16'h700 + i);
            step();
        end
        idle();
        checks++; if (buf_count_o[3:0] !== 4'd3) begin errors++; $display("FAIL rstmid_pre got %0d want 3", buf_count_o[3:0]); end
        reset = 1'b0;
        #1;
        checks++; if (buf_count_o[3:0] !== 4'd0 || buf_empty_o[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_clear got cnt=%0d e=%0b want cnt=0 e=1", buf_count_o[3:0], buf_empty_o[0]); end
        #1;
        reset = 1'b1;
        buf_read_i = 1'b1; buf_rvc_i = 1'b0;
        step();
        idle();
        checks++; if (buf_valid_o !== 1'b0 || buf_err_o !== 2'b10) begin
            errors++; $display("FAIL rstmid_read got v=%0b e=%b want v=0 e=10", buf_valid_o, buf_err_o); end
`ifdef VC_INPUT_BUFFER_CREDIT_EN
        checks++; if (credit_o !== 2'b00) begin errors++; $display("FAIL rstmid_credit got %b want 00", credit_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_full_rw();
        test_empty_read();
        test_diff_vc();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
